// File: rtl/yon_surucu.sv
// Two-motor direction driver: decodes obstacle codes into forward, turn and
// reverse manoeuvres, with timed turns and an automatic turn-around after reverse.
module yon_surucu #(
   parameter int unsigned DONUS_SURESI = 4,
   parameter int unsigned GERI_SURESI  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       yon_solbit,
   input  logic       yon_sagbit,
   input  logic       yon_gecerli,
   output logic       hazir,
   output logic       motor_sol_ileri,
   output logic       motor_sol_geri,
   output logic       motor_sag_ileri,
   output logic       motor_sag_geri,
   output logic       tamam,
   output logic [2:0] durum
);

   typedef enum logic [2:0] {
      BEKLE = 3'd0,
      ILERI = 3'd1,
      SOLA  = 3'd2,
      SAGA  = 3'd3,
      GERI  = 3'd4
   } durum_t;

   localparam logic [7:0] DONUS_YUK = 8'(DONUS_SURESI - 1);
   localparam logic [7:0] GERI_YUK  = 8'(GERI_SURESI - 1);

   durum_t     state;
   durum_t     komut;
   logic [7:0] sayac;
   logic [3:0] motor;

   // Motor pattern as {sol_ileri, sol_geri, sag_ileri, sag_geri}.
   function automatic logic [3:0] surus(input durum_t s);
      case (s)
         ILERI:   surus = 4'b1010;
         SOLA:    surus = 4'b0110;
         SAGA:    surus = 4'b1001;
         GERI:    surus = 4'b0101;
         default: surus = 4'b0000;
      endcase
   endfunction

   function automatic durum_t coz(input logic [1:0] kod);
      case (kod)
         2'b00:   coz = ILERI;
         2'b01:   coz = SOLA;
         2'b10:   coz = SAGA;
         default: coz = GERI;
      endcase
   endfunction

   assign komut = coz({yon_solbit, yon_sagbit});
   assign hazir = (state == BEKLE) || (state == ILERI);
   assign durum = state;

   assign {motor_sol_ileri, motor_sol_geri, motor_sag_ileri, motor_sag_geri} = motor;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BEKLE;
         sayac <= '0;
         motor <= '0;
         tamam <= 1'b0;
      end else begin
         tamam <= 1'b0;
         case (state)
            BEKLE, ILERI: begin
               if (yon_gecerli) begin
                  state <= komut;
                  motor <= surus(komut);
                  if (komut == GERI)
                     sayac <= GERI_YUK;
                  else if (komut == ILERI)
                     sayac <= '0;
                  else
                     sayac <= DONUS_YUK;
               end
            end
            SOLA, SAGA: begin
               if (sayac == '0) begin
                  state <= BEKLE;
                  motor <= '0;
                  tamam <= 1'b1;
               end else begin
                  sayac <= sayac - 8'd1;
               end
            end
            GERI: begin
               // Reverse always chains into a right turn; completion is reported after the turn.
               if (sayac == '0) begin
                  state <= SAGA;
                  motor <= surus(SAGA);
                  sayac <= DONUS_YUK;
               end else begin
                  sayac <= sayac - 8'd1;
               end
            end
            default: begin
               state <= BEKLE;
               motor <= '0;
               sayac <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_yon_surucu.sv
// Directed bench for yon_surucu: default-timing instance plus a 1-cycle-duration instance.
module tb_yon_surucu;

   logic clk = 1'b0;
   logic rst;

   logic       a_sol, a_sag, a_gecerli;
   logic       a_hazir, a_sol_ileri, a_sol_geri, a_sag_ileri, a_sag_geri, a_tamam;
   logic [2:0] a_durum;

   logic       b_sol, b_sag, b_gecerli;
   logic       b_hazir, b_sol_ileri, b_sol_geri, b_sag_ileri, b_sag_geri, b_tamam;
   logic [2:0] b_durum;

   int unsigned toplam = 0;
   int unsigned gecen  = 0;
   logic        izle   = 1'b0;

   always #5 clk = ~clk;

   yon_surucu dut_a (
      .clk(clk), .rst(rst),
      .yon_solbit(a_sol), .yon_sagbit(a_sag), .yon_gecerli(a_gecerli),
      .hazir(a_hazir),
      .motor_sol_ileri(a_sol_ileri), .motor_sol_geri(a_sol_geri),
      .motor_sag_ileri(a_sag_ileri), .motor_sag_geri(a_sag_geri),
      .tamam(a_tamam), .durum(a_durum)
   );

   yon_surucu #(.DONUS_SURESI(1), .GERI_SURESI(1)) dut_b (
      .clk(clk), .rst(rst),
      .yon_solbit(b_sol), .yon_sagbit(b_sag), .yon_gecerli(b_gecerli),
      .hazir(b_hazir),
      .motor_sol_ileri(b_sol_ileri), .motor_sol_geri(b_sol_geri),
      .motor_sag_ileri(b_sag_ileri), .motor_sag_geri(b_sag_geri),
      .tamam(b_tamam), .durum(b_durum)
   );

   task automatic kontrol(input string etiket, input logic [7:0] gozlenen, input logic [7:0] beklenen);
      toplam++;
      if (gozlenen !== beklenen)
         $display("FAIL %s: got %h expected %h at %0t", etiket, gozlenen, beklenen, $time);
      else
         gecen++;
   endtask

   task automatic adim();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] a_motor();
      return {a_sol_ileri, a_sol_geri, a_sag_ileri, a_sag_geri};
   endfunction

   function automatic logic [3:0] b_motor();
      return {b_sol_ileri, b_sol_geri, b_sag_ileri, b_sag_geri};
   endfunction

   // Same-side forward/reverse must never coexist on either instance.
   always @(negedge clk) begin
      if (izle) begin
         kontrol("cakisma_a", {7'd0, (a_sol_ileri & a_sol_geri) | (a_sag_ileri & a_sag_geri)}, 8'd0);
         kontrol("cakisma_b", {7'd0, (b_sol_ileri & b_sol_geri) | (b_sag_ileri & b_sag_geri)}, 8'd0);
      end
   end

   task automatic a_komut(input logic [1:0] kod);
      {a_sol, a_sag} = kod;
      a_gecerli = 1'b1;
      adim();
      a_gecerli = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      {a_sol, a_sag, a_gecerli} = '0;
      {b_sol, b_sag, b_gecerli} = '0;
      adim();
      adim();
      izle = 1'b1;
      rst = 1'b0;

      kontrol("rst_durum", a_durum, 0);
      kontrol("rst_motor", a_motor(), 0);
      kontrol("rst_tamam", a_tamam, 0);
      kontrol("rst_hazir", a_hazir, 1);

      a_komut(2'b00);
      kontrol("ileri_durum", a_durum, 1);
      kontrol("ileri_motor", a_motor(), 4'b1010);
      kontrol("ileri_hazir", a_hazir, 1);
      for (int i = 0; i < 20; i++) begin
         adim();
         kontrol("ileri_tut", {a_durum, a_motor()}, {3'd1, 4'b1010});
      end
      a_komut(2'b00);
      kontrol("ileri_tekrar", {a_durum, a_motor()}, {3'd1, 4'b1010});

      a_komut(2'b01);
      for (int i = 0; i < 4; i++) begin
         kontrol("sola_durum", a_durum, 2);
         kontrol("sola_motor", a_motor(), 4'b0110);
         kontrol("sola_hazir_tamam", {a_hazir, a_tamam}, 2'b00);
         adim();
      end
      kontrol("sola_son_durum", a_durum, 0);
      kontrol("sola_son_tamam", a_tamam, 1);
      kontrol("sola_son_motor", a_motor(), 0);
      kontrol("sola_son_hazir", a_hazir, 1);
      adim();
      kontrol("sola_tamam_tek", a_tamam, 0);

      a_komut(2'b11);
      for (int i = 0; i < 8; i++) begin
         kontrol("geri_durum", a_durum, 4);
         kontrol("geri_motor", a_motor(), 4'b0101);
         kontrol("geri_tamam", a_tamam, 0);
         adim();
      end
      for (int i = 0; i < 4; i++) begin
         kontrol("donus_durum", a_durum, 3);
         kontrol("donus_motor", a_motor(), 4'b1001);
         kontrol("donus_tamam", a_tamam, 0);
         adim();
      end
      kontrol("geri_son_durum", a_durum, 0);
      kontrol("geri_son_tamam", a_tamam, 1);
      adim();
      kontrol("geri_tamam_tek", a_tamam, 0);

      // Commands during SAGA are dropped; the one held into the tamam cycle is taken.
      a_komut(2'b10);
      for (int i = 0; i < 4; i++) begin
         kontrol("saga_durum", a_durum, 3);
         kontrol("saga_motor", a_motor(), 4'b1001);
         kontrol("saga_hazir", a_hazir, 0);
         {a_sol, a_sag} = (i % 2 == 1) ? 2'b11 : 2'b01;
         a_gecerli = 1'b1;
         adim();
      end
      kontrol("saga_son_durum", a_durum, 0);
      kontrol("saga_son_tamam", a_tamam, 1);
      kontrol("saga_son_hazir", a_hazir, 1);
      adim();
      a_gecerli = 1'b0;
      kontrol("tamamda_kabul", a_durum, 4);
      kontrol("tamamda_motor", a_motor(), 4'b0101);

      adim();
      adim();
      kontrol("geri_3_durum", a_durum, 4);
      rst = 1'b1;
      adim();
      rst = 1'b0;
      kontrol("iptal_motor", a_motor(), 0);
      kontrol("iptal_durum", a_durum, 0);
      kontrol("iptal_tamam", a_tamam, 0);
      kontrol("iptal_hazir", a_hazir, 1);
      adim();
      kontrol("iptal_tamam_yok", a_tamam, 0);

      {a_sol, a_sag} = 2'b00;
      a_gecerli = 1'b1;
      rst = 1'b1;
      adim();
      rst = 1'b0;
      a_gecerli = 1'b0;
      kontrol("rst_oncelik", a_durum, 0);

      {b_sol, b_sag} = 2'b11;
      b_gecerli = 1'b1;
      adim();
      b_gecerli = 1'b0;
      kontrol("b_geri", {b_durum, b_motor()}, {3'd4, 4'b0101});
      adim();
      kontrol("b_saga", {b_durum, b_motor()}, {3'd3, 4'b1001});
      kontrol("b_saga_tamam", b_tamam, 0);
      adim();
      kontrol("b_bekle", {b_durum, b_motor()}, {3'd0, 4'b0000});
      kontrol("b_tamam", b_tamam, 1);
      adim();
      kontrol("b_tamam_tek", b_tamam, 0);

      {b_sol, b_sag} = 2'b01;
      b_gecerli = 1'b1;
      adim();
      b_gecerli = 1'b0;
      kontrol("b_sola", {b_durum, b_motor()}, {3'd2, 4'b0110});
      adim();
      kontrol("b_sola_son", {b_durum, b_tamam}, {3'd0, 1'b1});

      izle = 1'b0;
      $display("%0d/%0d checks passed", gecen, toplam);
      $finish;
   end

endmodule

// File: doc/yon_surucu.md
YON_SURUCU -- requirements
Module: yon_surucu

Interface
REQ-001 Parameter DONUS_SURESI, default 4: number of cycles a turn manoeuvre drives the motors; legal range 1..255.
REQ-002 Parameter GERI_SURESI, default 8: number of cycles a reverse manoeuvre drives the motors; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 yon_solbit  input  1  direction code, high bit.
REQ-006 yon_sagbit  input  1  direction code, low bit.
REQ-007 yon_gecerli  input  1  command valid; the code is sampled only when valid and ready are both high.
REQ-008 hazir  output  1  ready; the block accepts a command this cycle.
REQ-009 motor_sol_ileri, motor_sol_geri, motor_sag_ileri, motor_sag_geri  output  1 each  left/right motor forward/reverse drives.
REQ-010 tamam  output  1  one-cycle pulse when a timed manoeuvre finishes.
REQ-011 durum  output  3  current state encoding: BEKLE=0, ILERI=1, SOLA=2, SAGA=3, GERI=4.

Function
REQ-012 Code decoding (yon_solbit,yon_sagbit) SHALL be: 00 -> ILERI, 01 (obstacle right) -> SOLA, 10 (obstacle left) -> SAGA, 11 (obstacle front) -> GERI.
REQ-013 A command SHALL be accepted on a rising edge where yon_gecerli=1 and hazir=1; the new state and its motor outputs SHALL be visible in the cycle after that edge (1-cycle latency).
REQ-014 hazir SHALL be combinationally 1 when durum is BEKLE or ILERI, and 0 in SOLA, SAGA and GERI.
REQ-015 Commands presented while hazir=0 SHALL be ignored and not queued.
REQ-016 Motor outputs SHALL be registered and decoded from state:
  - BEKLE: all 0.
  - ILERI: sol_ileri=1, sag_ileri=1.
  - SOLA: sol_geri=1, sag_ileri=1.
  - SAGA: sol_ileri=1, sag_geri=1.
  - GERI: sol_geri=1, sag_geri=1.
REQ-017 ileri and geri of the same side SHALL never be 1 in the same cycle.
REQ-018 ILERI SHALL persist indefinitely until a new command is accepted; accepting 00 while in ILERI SHALL keep ILERI with no glitch on the outputs.
REQ-019 Manoeuvre timing:
  - an 8-bit counter is loaded with duration-1 on entry to SOLA, SAGA or GERI, and decrements each cycle;
  - the state is left on the edge where the counter equals 0, so each state lasts exactly its duration in cycles.
REQ-020 SOLA and SAGA SHALL last DONUS_SURESI cycles, then go to BEKLE.
REQ-021 GERI SHALL last GERI_SURESI cycles, then go to SAGA for DONUS_SURESI cycles (turn-around), then to BEKLE.
REQ-022 tamam SHALL be 1 for exactly the first cycle in BEKLE after a completed manoeuvre, and 0 otherwise.
REQ-023 tamam SHALL NOT pulse on the GERI -> SAGA transition.
REQ-024 A command with yon_gecerli=1 in the first BEKLE cycle (tamam=1) SHALL be accepted normally.
REQ-025 The counter SHALL never wrap; a duration of 1 SHALL yield exactly one cycle in the state.

Reset
REQ-026 While rst=1 at a rising edge: state -> BEKLE, counter -> 0, all motor outputs -> 0, tamam -> 0, durum -> 0.
REQ-027 Reset SHALL take priority over any command or manoeuvre in progress.
REQ-028 hazir SHALL be 1 in the first cycle after reset is released.
REQ-029 An asserted rst SHALL abort a manoeuvre immediately at the next edge with no tamam pulse.

Verification
REQ-030 Reset, then 00 with valid -> next cycle durum=1, sol_ileri=sag_ileri=1, hazir=1; state held for 20 idle cycles.
REQ-031 In ILERI, accept 01 (DONUS=4) -> exactly 4 cycles of sol_geri=1, sag_ileri=1, hazir=0; then durum=0 with tamam=1 for 1 cycle.
REQ-032 Accept 11 (GERI=8, DONUS=4) -> 8 cycles of both geri, then 4 cycles of SAGA pattern, then BEKLE with a single tamam pulse; 13 cycles after the accept edge.
REQ-033 During SAGA, drive 01 and 11 with valid every cycle -> ignored, manoeuvre length unchanged; command held valid during the tamam cycle is accepted.
REQ-034 Assert rst mid-GERI (cycle 3) -> next cycle all outputs 0, durum=0, tamam=0, hazir=1.
REQ-035 Parameters DONUS=1, GERI=1, command 11 -> GERI 1 cycle, SAGA 1 cycle, then BEKLE; no overlap of ileri and geri on either side throughout.
